// File: rtl/multicycle_controller.sv
// Main sequencer for the shared multicycle RV32I datapath. A Moore FSM walks
// each instruction through 3-5 cycles; decoders derive selects, strobes, ALU op and ImmSrc.
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_e     state_q, state_d;
  logic [2:0] funct_alu;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= state_e'(RESET_STATE);
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_ALUWB;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:                  state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:                 state_d = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL, S_LUI: state_d = S_ALUWB;
      default:                   state_d = S_FETCH;
    endcase
  end

  // Only R-type can subtract; an I-type with Instr[30] set is still an add.
  always_comb begin
    funct_alu = ALU_ADD;
    case (funct3)
      3'b000:  funct_alu = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_alu = ALU_SLT;
      3'b100:  funct_alu = ALU_XOR;
      3'b110:  funct_alu = ALU_OR;
      3'b111:  funct_alu = ALU_AND;
      default: funct_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE:         ImmSrc = 3'b001;
      OP_BRANCH:        ImmSrc = 3'b010;
      OP_JAL:           ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
      default:          ImmSrc = 3'b000;
    endcase
  end

  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = funct_alu;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = funct_alu;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        PCWrite    = Zero ^ funct3[0];
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
      end
      default: ;
    endcase
  end

  assign State = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed test-plan instructions plus
// randomized instruction streams, compared every cycle against a per-instruction model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc, ALUControl;
  logic [3:0] State;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .State(State)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw, adr, memw, irw, regw;
    logic [1:0] rs, asa, asb;
    logic [2:0] imm, alu;
  } outs_t;

  outs_t dut_o;
  assign dut_o = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};

  int errors = 0;
  int checks = 0;

  // Per-cycle observations of the most recent instruction, used for literal pins.
  int obs_state[$];
  int obs_alu[$];
  int obs_pcw[$];
  int obs_imm[$];
  int obs_asa[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the ordered list of states an instruction visits, from its opcode class.
  function automatic void states_for(input logic [6:0] o, output int q[$]);
    q = {0, 1};
    case (o)
      7'b0000011: q = {q, 2, 3, 4};
      7'b0100011: q = {q, 2, 5};
      7'b0110011: q = {q, 6, 8};
      7'b0010011: q = {q, 7, 8};
      7'b1100011: q = {q, 9};
      7'b1101111: q = {q, 10, 8};
      7'b0110111: q = {q, 11, 8};
      7'b0010111: q = {q, 8};
      default: ;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    if (o == 7'b0100011) return 3'd1;
    if (o == 7'b1100011) return 3'd2;
    if (o == 7'b1101111) return 3'd3;
    if (o == 7'b0110111 || o == 7'b0010111) return 3'd4;
    return 3'd0;
  endfunction

  function automatic logic [2:0] alu_of(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    if (f3 == 3'b000) return (o == 7'b0110011 && f7) ? 3'd1 : 3'd0;
    if (f3 == 3'b010) return 3'd5;
    if (f3 == 3'b100) return 3'd4;
    if (f3 == 3'b110) return 3'd3;
    if (f3 == 3'b111) return 3'd2;
    return 3'd0;
  endfunction

  // Model: what each phase of an instruction must drive.
  function automatic outs_t expect_for(input int st, input logic [6:0] o, input logic [2:0] f3,
                                       input logic f7, input logic z);
    outs_t e = '0;
    e.imm = imm_of(o);
    if (st == 0) begin e.irw = 1; e.pcw = 1; e.asb = 2; e.rs = 2; end
    else if (st == 1) begin e.asa = 1; e.asb = 1; end
    else if (st == 2) begin e.asa = 2; e.asb = 1; end
    else if (st == 3) e.adr = 1;
    else if (st == 4) begin e.rs = 1; e.regw = 1; end
    else if (st == 5) begin e.adr = 1; e.memw = 1; end
    else if (st == 6) begin e.asa = 2; e.alu = alu_of(o, f3, f7); end
    else if (st == 7) begin e.asa = 2; e.asb = 1; e.alu = alu_of(o, f3, f7); end
    else if (st == 8) e.regw = 1;
    else if (st == 9) begin e.asa = 2; e.alu = 1; e.pcw = z ^ f3[0]; end
    else if (st == 10) begin e.asa = 1; e.asb = 2; e.pcw = 1; end
    else if (st == 11) begin e.asa = 3; e.asb = 1; end
    return e;
  endfunction

  // Runs one instruction starting in FETCH (#1 after a rising edge). zero_force < 0 randomises
  // Zero every cycle; max_cycles < 0 runs to completion, otherwise stops mid-instruction.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int zero_force, input int max_cycles);
    int seq[$];
    outs_t e;
    states_for(o, seq);
    op = o; funct3 = f3; funct7b5 = f7;
    obs_state = {}; obs_alu = {}; obs_pcw = {}; obs_imm = {}; obs_asa = {};
    for (int i = 0; i < seq.size(); i++) begin
      if (max_cycles >= 0 && i >= max_cycles) return;
      Zero = (zero_force < 0) ? 1'($urandom_range(0, 1)) : 1'(zero_force);
      @(negedge clk);
      e = expect_for(seq[i], o, f3, f7, Zero);
      check($sformatf("state op=%b step%0d", o, i), State, seq[i]);
      check($sformatf("outs op=%b f3=%b st%0d", o, f3, seq[i]), dut_o, e);
      obs_state.push_back(State); obs_alu.push_back(ALUControl); obs_pcw.push_back(PCWrite);
      obs_imm.push_back(ImmSrc); obs_asa.push_back(ALUSrcA);
      if (i == seq.size() - 1 && max_cycles < 0) begin
        @(posedge clk); #1;
      end else if (max_cycles < 0 || i + 1 < max_cycles) begin
        @(posedge clk); #1;
      end
    end
  endtask

  localparam logic [6:0] OPS [10] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                                      7'b1101111, 7'b0110111, 7'b0010111, 7'b1111111, 7'b0000000};

  initial begin
    reset = 1'b1; op = 7'b0000011; funct3 = '0; funct7b5 = 1'b0; Zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", State, 0);
    check("reset_fetch_strobes", {IRWrite, PCWrite, MemWrite, RegWrite}, 4'b1100);
    check("reset_fetch_selects", {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}, 10'b0_00_10_10_000);
    reset = 1'b0;

    // lw interrupted in MEMREAD by an asynchronous reset.
    run_instr(7'b0000011, 3'b010, 1'b0, -1, 4);
    check("pre_reset_memread", State, 3);
    #2 reset = 1'b1;
    #1;
    check("async_reset_state", State, 0);
    check("async_reset_no_regwrite", RegWrite, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_instr(7'b0000011, 3'b010, 1'b0, -1, -1);
    check("lw_len", obs_state.size(), 5);
    check("lw_last_state", obs_state[4], 4);

    run_instr(7'b0100011, 3'b010, 1'b0, -1, -1);
    check("sw_states", {obs_state[0], obs_state[1], obs_state[2], obs_state[3]}, {32'd0, 32'd1, 32'd2, 32'd5});
    check("sw_imm", obs_imm[2], 1);

    run_instr(7'b0110011, 3'b000, 1'b1, -1, -1);
    check("r_sub_alu", obs_alu[2], 1);
    run_instr(7'b0010011, 3'b000, 1'b1, -1, -1);
    check("i_addi_f7_alu", obs_alu[2], 0);
    run_instr(7'b0110011, 3'b111, 1'b0, -1, -1);
    check("r_and_alu", obs_alu[2], 2);

    for (int f = 0; f < 2; f++) begin
      for (int z = 0; z < 2; z++) begin
        run_instr(7'b1100011, 3'(f), 1'b0, z, -1);
        check($sformatf("branch_pcw f3=%0d z=%0d", f, z), obs_pcw[2], (z != f) ? 1 : 0);
        check("branch_len", obs_state.size(), 3);
      end
    end

    run_instr(7'b1101111, 3'b000, 1'b0, -1, -1);
    check("jal_state", obs_state[2], 10);
    check("jal_pcw", obs_pcw[2], 1);
    check("jal_imm", obs_imm[2], 3);
    run_instr(7'b0110111, 3'b000, 1'b0, -1, -1);
    check("lui_state", obs_state[2], 11);
    check("lui_asa", obs_asa[2], 3);
    check("lui_imm", obs_imm[2], 4);
    run_instr(7'b1111111, 3'b000, 1'b0, -1, -1);
    check("illegal_len", obs_state.size(), 2);
    check("illegal_decode_pcw", obs_pcw[1], 0);

    for (int n = 0; n < 200; n++) begin
      run_instr(OPS[$urandom_range(0, 9)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1, -1);
    end

    @(negedge clk);
    check("final_fetch", State, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
